// File: rtl/store_rmw.sv
// store_rmw: store-path narrowing unit that merges sub-word stores into a word-wide memory.
// Optional STORE_RMW_WSTRB_EN replaces read-modify-write with a lane-strobed write.
module store_rmw #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
`ifdef STORE_RMW_WSTRB_EN
    output logic [3:0]        mem_wstrb,
`endif
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_DONE, S_ERR} state_t;
    state_t r_state, w_next;
    logic [ADDR_W-3:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_strb;
    logic              w_bad, w_direct, w_accept;
    logic [31:0]       w_rep, w_mask;
    logic [3:0]        w_strb;

    assign w_bad = (req_size == 2'b11) | ((req_size == 2'b01) & req_addr[0]) |
                   ((req_size == 2'b10) & (|req_addr[1:0]));
    assign w_rep = (req_size == 2'b00) ? {4{req_data[7:0]}} :
                   (req_size == 2'b01) ? {2{req_data[15:0]}} : req_data;
    assign w_strb = (req_size == 2'b00) ? 4'b0001 << req_addr[1:0] :
                    (req_size == 2'b01) ? 4'b0011 << {req_addr[1], 1'b0} : 4'b1111;
    assign w_mask = {{8{r_strb[3]}}, {8{r_strb[2]}}, {8{r_strb[1]}}, {8{r_strb[0]}}};
    assign w_accept = (r_state == S_IDLE) & req_valid;
`ifdef STORE_RMW_WSTRB_EN
    assign w_direct = 1'b1;
    assign mem_wstrb = r_strb;
`else
    assign w_direct = (req_size == 2'b10);
`endif
    assign mem_addr = {r_addr, 2'b00};
    assign mem_wdata = r_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = w_bad ? S_ERR : (w_direct ? S_WRITE : S_READ);
            end
            S_READ: begin
                mem_rd = 1'b1;
                if (mem_ack) w_next = S_WRITE;
            end
            S_WRITE: begin
                mem_wr = 1'b1;
                if (mem_ack) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                err    = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Rejected requests leave the registers alone so mem_addr/mem_wdata never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
        end else if (w_accept && !w_bad) begin
            r_addr  <= req_addr[ADDR_W-1:2];
            r_wdata <= w_rep;
            r_strb  <= w_strb;
        end else if (r_state == S_READ && mem_ack) begin
            r_wdata <= (mem_rdata & ~w_mask) | (r_wdata & w_mask);
        end
    end
endmodule

// File: tb/tb_store_rmw.sv
// tb_store_rmw: directed plus randomized store sequences checked against a byte-array model.
module tb_store_rmw;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        done;
    logic        err;
`ifdef STORE_RMW_WSTRB_EN
    logic [3:0]  mem_wstrb;
    localparam bit WSTRB = 1'b1;
`else
    localparam bit WSTRB = 1'b0;
`endif
    int n_tests = 0;
    int n_fail  = 0;

    store_rmw #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
`ifdef STORE_RMW_WSTRB_EN
        .mem_wstrb(mem_wstrb),
`endif
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    // Memory word after the store: overwrite the addressed bytes with the low data bytes.
    function automatic logic [31:0] merged(input logic [31:0] mem, input logic [31:0] data,
                                           input logic [1:0] size, input logic [1:0] off);
        logic [7:0] b [4];
        int n = nbytes(size);
        for (int i = 0; i < 4; i++) b[i] = mem[8*i +: 8];
        for (int i = 0; i < n; i++) b[int'(off) + i] = data[8*i +: 8];
        return {b[3], b[2], b[1], b[0]};
    endfunction

    function automatic logic [31:0] replicated(input logic [31:0] data, input logic [1:0] size);
        logic [31:0] r = '0;
        int n = nbytes(size);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = data[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [3:0] strobes(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] s = '0;
        for (int i = 0; i < nbytes(size); i++) s[int'(off) + i] = 1'b1;
        return s;
    endfunction

    task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                         input logic [31:0] mword, input int rw, input int ww);
        int n = nbytes(size);
        bit legal = (size != 2'b11) && ((int'(addr[1:0]) % n) == 0);
        bit rmw = !WSTRB && size != 2'd2;
        logic [31:0] exp_w = WSTRB ? replicated(data, size) : merged(mword, data, size, addr[1:0]);
        int cyc = 1, reads = 0, rwait = 0, wwait = 0;
        bit fin = 1'b0;
        @(negedge clk);
        check("ready_before", req_ready, 1);
        req_valid = 1'b1; req_addr = addr; req_data = data; req_size = size;
        @(negedge clk);
        req_valid = 1'b0;
        if (!legal) begin
            check("err_pulse", err, 1);
            check("err_no_mem", {mem_rd, mem_wr}, 0);
            @(negedge clk);
            check("err_clear", err, 0);
            check("err_ready", req_ready, 1);
            return;
        end
        while (!fin && cyc < 100) begin
            if (mem_rd) begin
                reads++;
                check("rd_addr", mem_addr, {addr[31:2], 2'b00});
                check("rd_not_wr", mem_wr, 0);
                if (rwait == rw) begin mem_ack = 1'b1; mem_rdata = mword; end
                rwait++;
            end else if (mem_wr) begin
                check("wr_addr", mem_addr, {addr[31:2], 2'b00});
                check("wr_data", mem_wdata, exp_w);
`ifdef STORE_RMW_WSTRB_EN
                check("wr_strb", mem_wstrb, strobes(size, addr[1:0]));
`endif
                if (wwait == ww) mem_ack = 1'b1;
                wwait++;
            end else if (done) begin
                fin = 1'b1;
            end
            if (!fin) begin
                @(negedge clk);
                mem_ack = 1'b0;
                mem_rdata = $urandom;
                cyc++;
            end
        end
        check("done_seen", fin, 1);
        check("done_cycle", cyc, rmw ? 3 + rw + ww : 2 + ww);
        check("read_cycles", reads, rmw ? rw + 1 : 0);
        check("done_not_ready", req_ready, 0);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("ready_after", req_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        #12;
        check("rst_ready", req_ready, 1);
        check("rst_rd_wr", {mem_rd, mem_wr}, 0);
        check("rst_done_err", {done, err}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        store(32'h1002, 32'h0000_00AB, 2'd0, 32'h1122_3344, 0, 0);
        store(32'h2002, 32'h0000_BEEF, 2'd1, 32'hAAAA_AAAA, 0, 0);
        store(32'h2000, 32'h0000_BEEF, 2'd1, 32'hAAAA_AAAA, 0, 0);
        store(32'h3000, 32'hDEAD_BEEF, 2'd2, 32'h0, 0, 0);
        store(32'h4001, 32'h1234_5678, 2'd1, 32'h0, 0, 0);
        store(32'h4002, 32'h1234_5678, 2'd2, 32'h0, 0, 0);
        store(32'h4000, 32'h1234_5678, 2'd3, 32'h0, 0, 0);
        store(32'h1003, 32'h0000_00CD, 2'd0, 32'h5566_7788, 0, 0);
        store(32'h5001, 32'hFFFF_FF5A, 2'd0, 32'h0000_0000, 3, 2);

        // Illegal request held: err, then re-accepted in the following IDLE cycle.
        @(negedge clk);
        req_valid = 1'b1; req_size = 2'b11; req_addr = 32'h6000;
        @(negedge clk);
        check("held_err1", err, 1);
        check("held_err1_ready", req_ready, 0);
        @(negedge clk);
        check("held_err_gap", err, 0);
        check("held_err_ready", req_ready, 1);
        @(negedge clk);
        check("held_err2", err, 1);
        req_valid = 1'b0;
        @(negedge clk);

        // Word store held through DONE: the second copy starts only after IDLE.
        req_valid = 1'b1; req_size = 2'd2; req_addr = 32'h7000; req_data = 32'hCAFE_F00D;
        @(negedge clk);
        check("held_wr", mem_wr, 1);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("held_done", done, 1);
        check("held_done_ready", req_ready, 0);
        @(negedge clk);
        check("held_idle", req_ready, 1);
        check("held_idle_wr", mem_wr, 0);
        @(negedge clk);
        req_valid = 1'b0;
        check("held_wr2", mem_wr, 1);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("held_done2", done, 1);
        @(negedge clk);

        // Reset while in WRITE aborts without a done.
        req_valid = 1'b1; req_size = 2'd0; req_addr = 32'h1002; req_data = 32'hAB;
        @(negedge clk);
        req_valid = 1'b0;
        if (mem_rd) begin
            mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
            @(negedge clk);
            mem_ack = 1'b0;
        end
        check("abort_in_write", mem_wr, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_wr_drop", mem_wr, 0);
        check("abort_rd_low", mem_rd, 0);
        check("abort_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
            check("abort_idle", req_ready, 1);
        end

        for (int i = 0; i < 60; i++) begin
            store($urandom, $urandom, 2'($urandom_range(0, 3)), $urandom,
                  $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
